score_bcd_conv: RTL and testbench
=================================

# score_bcd_conv

Sequential binary-to-BCD converter between the `scoring` stage and the score digit displays. On a `start` pulse it captures the 15-bit binary score and runs an iterative shift-add-3 (double-dabble) conversion, one bit per clock. It then presents four registered BCD digits to the score display decoders. Scores above 9999 saturate to 9999 and raise a sticky-per-result overflow flag.

## Interface
- `IN_W`, default 15, width of binary score input; fixed iteration count equals `IN_W`.
- `MAX_VAL`, default 9999, saturation value; must fit in 4 BCD digits.
- `clk`  in  1  system clock; the single clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  conversion request, sampled only in IDLE.
- `score`  in  IN_W  unsigned binary score, sampled on the accepting edge.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when new digits are valid.
- `overflow`  out  1  last converted score exceeded MAX_VAL.
- `score1`  out  4  thousands digit (BCD).
- `score2`  out  4  hundreds digit.
- `score3`  out  4  tens digit.
- `score4`  out  4  ones digit.

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - On `start`=1, latch `score` into a working register.
  - If `score` > MAX_VAL, load MAX_VAL instead and set the internal ovf flag; otherwise clear it.
  - Clear the 16-bit BCD accumulator, load the bit counter with IN_W, and go to SHIFT.
- SHIFT, one iteration per clock:
  - For each BCD nibble ≥ 5, add 3. Compute all four nibbles from pre-iteration values.
  - Then shift {bcd, bin} left by 1 and decrement the counter.
  - When the counter reaches 1 (the last iteration), write the final digits to `score1..score4` and `ovf` to `overflow`, pulse `done`, and return to IDLE.
- Outputs hold their last result until the next completion. Intermediate accumulator values never appear on `score1..score4`.
- `start` while in SHIFT is ignored; the request is not queued.
- `start` held high continuously retriggers a conversion each time IDLE is reached.
- Nibble adds are 4-bit with no carry between nibbles. Because the input is ≤ 9999, no nibble ever exceeds 9 after the final shift.
- Reset, from any state and including mid-conversion: go to IDLE and clear `busy`, `done`, `overflow`, `score1..score4`, and the accumulator and counter to 0. A partial result is discarded.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- `busy`=1 in the cycles after E0 through E14, and 0 after E15.
- Iterations occur at E1..E15, 15 clocks total for IN_W=15.
- Digits, `overflow`, and `done`=1 are all registered at E15 and visible in the cycle after it. `done` returns to 0 at E16.
- Latency from the `start` sampling edge to valid digits is IN_W clocks.
- A `start` sampled at E15 is not accepted, because the state is still SHIFT. A `start` at E16 is accepted, so the minimum back-to-back period is IN_W+1 clocks.
- `score` may change freely after E0; only the E0 value is used.
- Reset values: `busy`=0, `done`=0, `overflow`=0, `score1..4`=0.

## Test plan
- Reset then idle 20 clocks → all outputs 0, `done` never pulses.
- `score`=1234, `start` pulse at E0 → `busy` high for 15 cycles; at E15 `done`=1 for one cycle with digits 1,2,3,4 and `overflow`=0.
- Conversions of 0, 9, 10, 99, 100, 9999 → digits 0000, 0009, 0010, 0099, 0100, 9999, each with `overflow`=0.
- Conversions of 10000 and 32767 → digits 9999 and `overflow`=1; a following conversion of 42 → 0042 with `overflow`=0.
- Convert 5678, then pulse `start` with `score`=1111 at E5 and E15 → both pulses ignored, result 5678; a `start` at E16 → 1111 after 15 more clocks.
- Convert 4321 to completion, then start 8765 and assert `reset` at E7 → all outputs 0 the next cycle, no `done`. Releasing reset and starting 2468 → 2468 after 15 clocks.

Source files
------------

// File: rtl/score_bcd_conv.sv
// Sequential double-dabble converter: captures a binary score on start and
// produces four registered BCD digits IN_W clocks later, saturating at MAX_VAL.
module score_bcd_conv #(
  parameter int IN_W    = 15,
  parameter int MAX_VAL = 9999
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] score,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [3:0]      score1,
  output logic [3:0]      score2,
  output logic [3:0]      score3,
  output logic [3:0]      score4
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [IN_W-1:0] MAX_VAL_W = IN_W'(MAX_VAL);

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } state_t;

  state_t          state_q;
  logic [IN_W-1:0] bin_q;
  logic [IN_W-1:0] bin_d;
  logic [15:0]     bcd_q;
  logic [15:0]     bcd_d;
  logic [15:0]     bcd_adj;
  logic [IN_W+15:0] shifted;
  logic [CNT_W-1:0] cnt_q;
  logic            ovf_q;
  logic            score_over;

  logic            busy_q;
  logic            done_q;
  logic            overflow_q;
  logic [15:0]     digits_q;

  assign score_over = (score > MAX_VAL_W);

  // Each nibble is corrected from its pre-iteration value, then the whole
  // {bcd, bin} pair shifts left; nibble adds never carry into a neighbour.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
    bcd_d   = shifted[IN_W+15 -: 16];
    bin_d   = shifted[IN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      digits_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= score_over ? MAX_VAL_W : score;
            ovf_q   <= score_over;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(IN_W);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CNT_W'(1);
          // The last iteration publishes straight from the next-state value,
          // so partial accumulator contents never reach the digit outputs.
          if (cnt_q == CNT_W'(1)) begin
            digits_q   <= bcd_d;
            overflow_q <= ovf_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign score1   = digits_q[15:12];
  assign score2   = digits_q[11:8];
  assign score3   = digits_q[7:4];
  assign score4   = digits_q[3:0];

endmodule

// File: tb/tb_score_bcd_conv.sv
// Self-checking bench for score_bcd_conv: directed scenarios plus random
// scores, compared against a decimal-arithmetic reference model.
module tb_score_bcd_conv;

  localparam int IN_W    = 15;
  localparam int MAX_VAL = 9999;

  logic            clk;
  logic            reset;
  logic            start;
  logic [IN_W-1:0] score;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [3:0]      score1;
  logic [3:0]      score2;
  logic [3:0]      score3;
  logic [3:0]      score4;

  int          compareCount = 0;
  int          failCount    = 0;
  logic [15:0] expBcd;
  logic        expOvf;

  score_bcd_conv #(.IN_W(IN_W), .MAX_VAL(MAX_VAL)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .score    (score),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .score1   (score1),
    .score2   (score2),
    .score3   (score3),
    .score4   (score4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: saturate, then split into decimal digits arithmetically.
  function automatic logic [15:0] refBcd(input int value);
    int s;
    s = (value > MAX_VAL) ? MAX_VAL : value;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic expBusy, input logic expDone);
    checkOutput({tag, "_busy"}, 32'(busy), 32'(expBusy));
    checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(expOvf));
    checkOutput({tag, "_digits"}, 32'({score1, score2, score3, score4}), 32'(expBcd));
  endtask

  // Starts a conversion (immediately when backToBack, else at the next
  // negedge) and checks every cycle from E0 through E15; optional extra start
  // pulses are presented so that they are sampled at edges pulseA/pulseB.
  task automatic applyStimulus(input int value, input bit backToBack,
                               input int pulseA, input int pulseB, input string tag);
    if (!backToBack) @(negedge clk);
    score = IN_W'(value);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      start = ((k + 1) == pulseA) || ((k + 1) == pulseB);
      score = start ? IN_W'(1111) : IN_W'($urandom);
      if (k == 15) begin
        expBcd = refBcd(value);
        expOvf = (value > MAX_VAL);
      end
      checkAll($sformatf("%s_e%0d", tag, k), k < 15, k == 15);
    end
    start = 1'b0;
  endtask

  initial begin
    int dirVals[6] = '{0, 9, 10, 99, 100, 9999};
    int v;
    bit b2b;

    reset  = 1'b1;
    start  = 1'b0;
    score  = '0;
    expBcd = '0;
    expOvf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAll("reset", 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle%0d_done", i), 32'(done), 32'd0);
      checkOutput($sformatf("idle%0d_digits", i),
                  32'({score1, score2, score3, score4, overflow, busy}), 32'd0);
    end

    $display("[TB] directed conversions");
    applyStimulus(1234, 1'b0, -1, -1, "c1234");
    foreach (dirVals[i]) applyStimulus(dirVals[i], 1'b0, -1, -1, $sformatf("c%0d", dirVals[i]));
    applyStimulus(10000, 1'b0, -1, -1, "c10000");
    applyStimulus(32767, 1'b0, -1, -1, "c32767");
    applyStimulus(42, 1'b0, -1, -1, "c42");

    $display("[TB] ignored and back-to-back starts");
    applyStimulus(5678, 1'b0, 5, 15, "c5678");
    applyStimulus(1111, 1'b1, -1, -1, "c1111");

    $display("[TB] reset mid-conversion");
    applyStimulus(4321, 1'b0, -1, -1, "c4321");
    @(negedge clk);
    score = IN_W'(8765);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      checkAll($sformatf("c8765_e%0d", k), 1'b1, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    expBcd = '0;
    expOvf = 1'b0;
    checkAll("rst_mid", 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(2468, 1'b0, -1, -1, "c2468");

    $display("[TB] random conversions");
    for (int i = 0; i < 30; i++) begin
      v   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 32767))
                                        : int'($urandom_range(0, 9999));
      b2b = 1'($urandom_range(0, 1));
      applyStimulus(v, b2b, -1, -1, $sformatf("rnd%0d_%0d", i, v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
